// File: rtl/tmds_encoder_dvi.sv
// tmds_encoder_dvi: single-channel DVI TMDS encoder.
// Two pipeline stages: transition minimisation, then DC balancing
// against a running disparity (bias) register. Output feeds a 10:1
// serializer in the same pixel clock domain; bit 0 goes out first.
module tmds_encoder_dvi (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic [7:0] i_data,
  input  logic       i_c0,
  input  logic       i_c1,
  input  logic       i_de,
  output logic [9:0] o_tmds
);

  // Control-period symbols, indexed by {c1, c0}.
  localparam logic [9:0] CTRL_00 = 10'b1101010100;
  localparam logic [9:0] CTRL_01 = 10'b0010101011;
  localparam logic [9:0] CTRL_10 = 10'b0101010100;
  localparam logic [9:0] CTRL_11 = 10'b1010101011;

  // Stage-1 combinational signals.
  logic [3:0] w_n1;
  logic       w_use_xnor;
  logic [8:0] w_qm;
  logic [3:0] w_n1_qm;

  // Stage-1 registers.
  logic [8:0] r_qm;
  logic [3:0] r_n1q;
  logic       r_de;
  logic       r_c0;
  logic       r_c1;

  // Stage-2 combinational signals.
  logic signed [4:0] w_n1q_s;
  logic signed [4:0] w_n0q_s;
  logic signed [4:0] w_disp;
  logic signed [4:0] w_qm8_x2;
  logic signed [4:0] w_nqm8_x2;
  logic              w_case_a;
  logic              w_case_b;
  logic [9:0]        w_next_tmds;
  logic signed [4:0] w_next_bias;

  // Stage-2 registers.
  logic [9:0]        r_tmds;
  logic signed [4:0] r_bias;

  // Count the ones in the incoming pixel to choose the XOR or XNOR chain.
  always_comb begin
    w_n1 = 4'd0;
    for (int i = 0; i < 8; i++) begin
      w_n1 = w_n1 + {3'b000, i_data[i]};
    end
  end

  // Ties at four ones are broken on bit 0 so both paths stay reachable.
  assign w_use_xnor = (w_n1 > 4'd4) || ((w_n1 == 4'd4) && !i_data[0]);

  // Build the transition-minimised word; bit 8 flags which chain was used.
  always_comb begin
    w_qm    = '0;
    w_qm[0] = i_data[0];
    for (int i = 1; i < 8; i++) begin
      w_qm[i] = w_use_xnor ? ~(w_qm[i-1] ^ i_data[i]) : (w_qm[i-1] ^ i_data[i]);
    end
    w_qm[8] = ~w_use_xnor;
  end

  // Pre-count the ones of q_m[7:0] so stage 2 only has to compare and add.
  always_comb begin
    w_n1_qm = 4'd0;
    for (int i = 0; i < 8; i++) begin
      w_n1_qm = w_n1_qm + {3'b000, w_qm[i]};
    end
  end

  // Stage-1 pipeline registers; q_m is computed even during control periods.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_qm  <= '0;
      r_n1q <= '0;
      r_de  <= 1'b0;
      r_c0  <= 1'b0;
      r_c1  <= 1'b0;
    end else begin
      r_qm  <= w_qm;
      r_n1q <= w_n1_qm;
      r_de  <= i_de;
      r_c0  <= i_c0;
      r_c1  <= i_c1;
    end
  end

  // Signed disparity of q_m[7:0]: ones minus zeros, range -8..+8.
  assign w_n1q_s   = signed'({1'b0, r_n1q});
  assign w_n0q_s   = 5'sd8 - w_n1q_s;
  assign w_disp    = w_n1q_s - w_n0q_s;
  assign w_qm8_x2  = r_qm[8] ? 5'sd2 : 5'sd0;
  assign w_nqm8_x2 = r_qm[8] ? 5'sd0 : 5'sd2;

  // Case A: no history to correct or a balanced word; case B: word would
  // push the bias further in the direction it already leans, so invert.
  assign w_case_a = (r_bias == 5'sd0) || (r_n1q == 4'd4);
  assign w_case_b = ((r_bias > 5'sd0) && (r_n1q > 4'd4)) ||
                    ((r_bias < 5'sd0) && (r_n1q < 4'd4));

  // Choose the output symbol and the next running disparity.
  always_comb begin
    w_next_tmds = CTRL_00;
    w_next_bias = 5'sd0;
    if (!r_de) begin
      case ({r_c1, r_c0})
        2'b00:   w_next_tmds = CTRL_00;
        2'b01:   w_next_tmds = CTRL_01;
        2'b10:   w_next_tmds = CTRL_10;
        default: w_next_tmds = CTRL_11;
      endcase
      w_next_bias = 5'sd0;
    end else if (w_case_a) begin
      w_next_tmds = {~r_qm[8], r_qm[8], (r_qm[8] ? r_qm[7:0] : ~r_qm[7:0])};
      w_next_bias = r_qm[8] ? (r_bias + w_disp) : (r_bias - w_disp);
    end else if (w_case_b) begin
      w_next_tmds = {1'b1, r_qm[8], ~r_qm[7:0]};
      w_next_bias = r_bias + w_qm8_x2 - w_disp;
    end else begin
      w_next_tmds = {1'b0, r_qm[8], r_qm[7:0]};
      w_next_bias = r_bias - w_nqm8_x2 + w_disp;
    end
  end

  // Stage-2 registers; reset parks the link on the c1c0=00 control symbol.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_tmds <= CTRL_00;
      r_bias <= 5'sd0;
    end else begin
      r_tmds <= w_next_tmds;
      r_bias <= w_next_bias;
    end
  end

  assign o_tmds = r_tmds;

endmodule

// File: tb/tb_tmds_encoder_dvi.sv
// tb_tmds_encoder_dvi: directed vector table, reset corner cases and a
// long random run against a behavioural TMDS model with decode-back.
module tb_tmds_encoder_dvi;

  localparam logic [9:0] SYM_C00 = 10'b1101010100;

  logic       clk;
  logic       rstN;
  logic [7:0] data;
  logic       c0;
  logic       c1;
  logic       de;
  logic [9:0] tmds;

  int total = 0;
  int bad   = 0;

  tmds_encoder_dvi dut (
    .i_clk   (clk),
    .i_rst_n (rstN),
    .i_data  (data),
    .i_c0    (c0),
    .i_c1    (c1),
    .i_de    (de),
    .o_tmds  (tmds)
  );

  // Free-running pixel clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Hard time limit so the run always ends.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got timeout required completion");
    $fatal(1, "[TB] watchdog expired");
  end

  typedef struct {
    logic [7:0] data;
    logic       de;
    logic       c1;
    logic       c0;
    logic [9:0] expTmds;
    int         expBias;
  } vec_t;

  typedef struct {
    logic [7:0] data;
    logic       de;
    logic       c1;
    logic       c0;
  } inRec_t;

  vec_t   vecs[15];
  int     mBias;
  inRec_t mStage;
  bit     seen[256];

  task automatic checkOutput(input string name, input int actual, input int expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %0d required %0d (t=%0t)", name, actual, expected, $time);
    end
  endtask

  function automatic int dutBias();
    return int'($signed(dut.r_bias));
  endfunction

  // Drive one set of inputs and advance to just after the next rising edge.
  task automatic applyStimulus(input logic [7:0] d, input logic e, input logic k1, input logic k0);
    data = d;
    de   = e;
    c1   = k1;
    c0   = k0;
    @(posedge clk);
    #1;
  endtask

  // Behavioural encoder: counts with $countones, integer disparity.
  task automatic modelEncode(input inRec_t r, output logic [9:0] o);
    int         n1;
    int         ones;
    int         disp;
    bit         useX;
    logic [8:0] qm;
    if (!r.de) begin
      case ({r.c1, r.c0})
        2'b00:   o = 10'b1101010100;
        2'b01:   o = 10'b0010101011;
        2'b10:   o = 10'b0101010100;
        default: o = 10'b1010101011;
      endcase
      mBias = 0;
    end else begin
      n1   = $countones(r.data);
      useX = (n1 > 4) || (n1 == 4 && r.data[0] == 1'b0);
      qm[0] = r.data[0];
      for (int i = 1; i < 8; i++)
        qm[i] = useX ? ~(qm[i-1] ^ r.data[i]) : (qm[i-1] ^ r.data[i]);
      qm[8] = !useX;
      ones = $countones(qm[7:0]);
      disp = ones - (8 - ones);
      if (mBias == 0 || disp == 0) begin
        o = {~qm[8], qm[8], (qm[8] ? qm[7:0] : ~qm[7:0])};
        mBias = mBias + (qm[8] ? disp : -disp);
      end else if ((mBias > 0 && disp > 0) || (mBias < 0 && disp < 0)) begin
        o = {1'b1, qm[8], ~qm[7:0]};
        mBias = mBias + 2 * int'(qm[8]) - disp;
      end else begin
        o = {1'b0, qm[8], qm[7:0]};
        mBias = mBias + disp - 2 * int'(!qm[8]);
      end
    end
  endtask

  // Receiver-side decode used to confirm every data symbol round-trips.
  function automatic logic [7:0] tmdsDecode(input logic [9:0] s);
    logic [7:0] t;
    logic [7:0] d;
    t = s[9] ? ~s[7:0] : s[7:0];
    d[0] = t[0];
    for (int i = 1; i < 8; i++)
      d[i] = s[8] ? (t[i] ^ t[i-1]) : ~(t[i] ^ t[i-1]);
    return d;
  endfunction

  // One random-run cycle: drive, clock, then compare against the model.
  task automatic modelCycle(input logic [7:0] d, input logic e, input logic k1, input logic k0);
    inRec_t     cur;
    inRec_t     prev;
    logic [9:0] exp;
    cur.data = d;
    cur.de   = e;
    cur.c1   = k1;
    cur.c0   = k0;
    prev     = mStage;
    applyStimulus(d, e, k1, k0);
    modelEncode(prev, exp);
    mStage = cur;
    checkOutput("rand_tmds", int'(tmds), int'(exp));
    checkOutput("rand_bias", dutBias(), mBias);
    checkOutput("rand_biasRange", int'(dutBias() >= -10 && dutBias() <= 10), 1);
    if (prev.de) begin
      checkOutput("rand_decode", int'(tmdsDecode(tmds)), int'(prev.data));
      if (tmdsDecode(tmds) == prev.data) seen[prev.data] = 1'b1;
    end
  endtask

  initial begin
    int nSeen;
    int deRun;
    logic curDe;

    vecs[0]  = '{8'h00, 1'b0, 1'b0, 1'b0, 10'b1101010100, 0};
    vecs[1]  = '{8'h00, 1'b0, 1'b0, 1'b1, 10'b0010101011, 0};
    vecs[2]  = '{8'h00, 1'b0, 1'b1, 1'b0, 10'b0101010100, 0};
    vecs[3]  = '{8'h00, 1'b0, 1'b1, 1'b1, 10'b1010101011, 0};
    vecs[4]  = '{8'h00, 1'b1, 1'b0, 1'b0, 10'b0100000000, -8};
    vecs[5]  = '{8'h00, 1'b1, 1'b0, 1'b0, 10'b1111111111, 2};
    vecs[6]  = '{8'h00, 1'b1, 1'b0, 1'b0, 10'b0100000000, -6};
    vecs[7]  = '{8'h00, 1'b0, 1'b0, 1'b0, 10'b1101010100, 0};
    vecs[8]  = '{8'h00, 1'b1, 1'b0, 1'b0, 10'b0100000000, -8};
    vecs[9]  = '{8'hFF, 1'b0, 1'b1, 1'b1, 10'b1010101011, 0};
    vecs[10] = '{8'hFF, 1'b1, 1'b1, 1'b1, 10'b1000000000, -8};
    vecs[11] = '{8'hFF, 1'b1, 1'b0, 1'b0, 10'b0011111111, -2};
    vecs[12] = '{8'h0F, 1'b1, 1'b0, 1'b0, 10'b1111111010, 4};
    vecs[13] = '{8'hF0, 1'b1, 1'b0, 1'b0, 10'b1000000101, 0};
    vecs[14] = '{8'h55, 1'b1, 1'b0, 1'b0, 10'b0100110011, 0};

    $display("[TB] start");
    rstN = 1'b0;
    data = 8'h00;
    de   = 1'b0;
    c0   = 1'b0;
    c1   = 1'b0;

    // Held in reset with random inputs: output and bias stay at reset values.
    for (int i = 0; i < 8; i++) begin
      applyStimulus(8'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
      checkOutput("rst_tmds", int'(tmds), int'(SYM_C00));
      checkOutput("rst_bias", dutBias(), 0);
    end
    rstN = 1'b1;

    // Directed table: vector k emerges just after edge k+1.
    for (int k = 0; k < 15; k++) begin
      applyStimulus(vecs[k].data, vecs[k].de, vecs[k].c1, vecs[k].c0);
      if (k == 0) begin
        checkOutput("vec_first_tmds", int'(tmds), int'(SYM_C00));
        checkOutput("vec_first_bias", dutBias(), 0);
      end else begin
        checkOutput($sformatf("vec%0d_tmds", k - 1), int'(tmds), int'(vecs[k-1].expTmds));
        checkOutput($sformatf("vec%0d_bias", k - 1), dutBias(), vecs[k-1].expBias);
      end
    end
    applyStimulus(8'h00, 1'b0, 1'b0, 1'b0);
    checkOutput("vec14_tmds", int'(tmds), int'(vecs[14].expTmds));
    checkOutput("vec14_bias", dutBias(), vecs[14].expBias);

    // Async reset between edges while data is flowing.
    applyStimulus(8'h00, 1'b1, 1'b0, 1'b0);
    applyStimulus(8'h00, 1'b1, 1'b0, 1'b0);
    checkOutput("pre_reset_tmds", int'(tmds), int'(10'b0100000000));
    #2;
    rstN = 1'b0;
    #1;
    checkOutput("async_reset_tmds", int'(tmds), int'(SYM_C00));
    checkOutput("async_reset_bias", dutBias(), 0);
    @(posedge clk);
    #1;
    rstN = 1'b1;
    applyStimulus(8'h00, 1'b1, 1'b0, 1'b0);
    checkOutput("post_reset_ctrl", int'(tmds), int'(SYM_C00));
    applyStimulus(8'h00, 1'b1, 1'b0, 1'b0);
    checkOutput("post_reset_data", int'(tmds), int'(10'b0100000000));

    // Fresh reset before the model-checked run.
    rstN = 1'b0;
    #2;
    @(posedge clk);
    #1;
    rstN   = 1'b1;
    mBias  = 0;
    mStage = '{8'h00, 1'b0, 1'b0, 1'b0};
    for (int i = 0; i < 256; i++) seen[i] = 1'b0;

    // Sweep every code as data, then a random mix of data and control runs.
    for (int i = 0; i < 256; i++)
      modelCycle(8'(i), 1'b1, 1'($urandom), 1'($urandom));
    curDe = 1'b0;
    deRun = 0;
    for (int i = 0; i < 2000; i++) begin
      if (deRun == 0) begin
        curDe = ~curDe;
        deRun = curDe ? int'($urandom_range(1, 40)) : int'($urandom_range(1, 6));
      end
      deRun--;
      modelCycle(8'($urandom), curDe, 1'($urandom), 1'($urandom));
    end
    modelCycle(8'h00, 1'b0, 1'b0, 1'b0);

    nSeen = 0;
    for (int i = 0; i < 256; i++) if (seen[i]) nSeen++;
    checkOutput("all_codes_decoded", nSeen, 256);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
